// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: register offsets and FSM encoding shared by the packet arbiter.
package axis_arb_pkg;
    localparam logic [11:0] ARB_CTRL_OFS = 12'h0;
    localparam logic [11:0] ARB_MASK_OFS = 12'h4;
    localparam logic [11:0] ARB_STAT_OFS = 12'h8;
    localparam logic [11:0] ARB_CNT_OFS  = 12'hC;
    localparam logic [0:0]  ST_IDLE      = 1'b0;
    localparam logic [0:0]  ST_XFER      = 1'b1;
endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: 2-entry skid buffer; o_valid, o_data and o_ready all come straight from flops,
// so there is no combinational path from i_ready to o_ready.
module axis_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);
    logic         r_valid, r_skid_valid;
    logic [W-1:0] r_data, r_skid_data;
    logic         w_acc, w_free;
    assign o_ready = ~r_skid_valid;
    assign w_acc   = i_valid & ~r_skid_valid;
    assign w_free  = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (w_free) begin
            r_valid      <= r_skid_valid | w_acc;
            r_data       <= r_skid_valid ? r_skid_data : w_acc ? i_data : r_data;
            r_skid_valid <= 1'b0;
        end else if (w_acc) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= i_data;
        end
    end
endmodule

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-granular round-robin merge of NUM_IN AXI-stream inputs, APB configured.
// Define AXIS_PKT_ARB_CNT_EN to add the PKT_CNT register at 0xC.
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int DATA_W = 8,
    parameter int ID_W   = 3
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_IN-1:0]        s_axis_tvalid,
    input  logic [NUM_IN*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_IN-1:0]        s_axis_tlast,
    output logic [NUM_IN-1:0]        s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tlast,
    output logic [ID_W-1:0]          m_axis_tid,
    input  logic                     m_axis_tready,
    input  logic [11:0]              paddr,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [31:0]              pwdata,
    output logic [31:0]              prdata,
    output logic                     pready,
    output logic                     pslverr
);
    localparam int PW = DATA_W + 1 + ID_W;
    logic [0:0]        r_state;
    logic [ID_W-1:0]   r_grant, r_last_grant;
    logic              r_enable;
    logic [NUM_IN-1:0] r_mask;
    logic [31:0]       r_prdata;
    logic              r_pslverr;
    logic [NUM_IN-1:0] w_req, w_sel;
    logic [ID_W-1:0]   w_pick;
    logic [DATA_W-1:0] w_data;
    logic [PW-1:0]     w_m_payload;
    logic [31:0]       w_status;
    logic              w_skid_rdy, w_acc, w_eop, w_setup, w_unused;
    assign w_req    = s_axis_tvalid & r_mask & {NUM_IN{r_enable}};
    assign w_sel    = {{(NUM_IN-1){1'b0}}, 1'b1} << r_grant;
    assign s_axis_tready = (r_state == ST_XFER && w_skid_rdy) ? w_sel : '0;
    assign w_acc    = |(s_axis_tvalid & s_axis_tready);
    assign w_eop    = w_acc & |(s_axis_tlast & w_sel);
    assign w_setup  = psel & ~penable;
    assign w_status = {23'd0, r_state == ST_XFER, 5'd0, 3'(r_grant)};
    assign w_unused = ^pwdata;
    // Walk the doubled request vector upward from last_grant+1; the smallest index wins.
    always_comb begin
        w_pick = r_last_grant;
        for (int k = 2*NUM_IN-1; k >= 0; k--)
            if (k > int'(r_last_grant) && w_req[k % NUM_IN]) w_pick = ID_W'(k % NUM_IN);
    end
    always_comb begin
        w_data = '0;
        for (int i = 0; i < NUM_IN; i++)
            if (w_sel[i]) w_data = s_axis_tdata[i*DATA_W +: DATA_W];
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= ID_W'(NUM_IN-1);
        end else if (r_state == ST_IDLE) begin
            if (|w_req) begin
                r_grant <= w_pick;
                r_state <= ST_XFER;
            end
        end else if (w_eop) begin
            r_last_grant <= r_grant;
            r_state      <= ST_IDLE;
        end
    end
    axis_skid_buf #(.W(PW)) u_skid (
        .clk     (clk),
        .resetn  (resetn),
        .i_valid (w_acc),
        .i_data  ({r_grant, |(s_axis_tlast & w_sel), w_data}),
        .o_ready (w_skid_rdy),
        .o_valid (m_axis_tvalid),
        .o_data  (w_m_payload),
        .i_ready (m_axis_tready)
    );
    assign {m_axis_tid, m_axis_tlast, m_axis_tdata} = w_m_payload;
`ifdef AXIS_PKT_ARB_CNT_EN
    logic [31:0] r_pkt_cnt;
    // A clear from APB takes priority over a same-cycle end of packet.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_pkt_cnt <= '0;
        else if (w_setup && pwrite && paddr == ARB_CNT_OFS) r_pkt_cnt <= '0;
        else if (w_eop) r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end
`endif
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_enable  <= 1'b1;
            r_mask    <= '1;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else begin
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
            if (w_setup) begin
                case (paddr)
                    ARB_CTRL_OFS: if (pwrite) r_enable <= pwdata[0]; else r_prdata <= {31'd0, r_enable};
                    ARB_MASK_OFS: if (pwrite) r_mask <= pwdata[NUM_IN-1:0]; else r_prdata <= 32'(r_mask);
                    ARB_STAT_OFS: if (pwrite) r_pslverr <= 1'b1; else r_prdata <= w_status;
`ifdef AXIS_PKT_ARB_CNT_EN
                    ARB_CNT_OFS:  r_prdata <= pwrite ? 32'd0 : r_pkt_cnt;
`endif
                    default:      r_pslverr <= 1'b1;
                endcase
            end
        end
    end
    assign prdata  = r_prdata;
    assign pready  = 1'b1;
    assign pslverr = r_pslverr;
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: scoreboard bench; a packet-level round-robin model predicts the merged stream.
module tb_axis_pkt_arbiter;
    localparam int NI = 2, DW = 8, IW = 3, PW = DW + 1 + IW;
    logic clk = 1'b0, resetn;
    logic [NI-1:0] s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [NI*DW-1:0] s_axis_tdata;
    logic m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [IW-1:0] m_axis_tid;
    logic [11:0] paddr;
    logic psel, penable, pwrite, pready, pslverr;
    logic [31:0] pwdata, prdata;
    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic [PW-1:0] eq[$];
    logic [DW-1:0] dq[NI][$], mq[NI][$];
    bit lq[NI][$], ml[NI][$];
    int mlast = NI - 1, pkts = 0, rmode = 0;
    bit bub = 0, gap_chk = 0, have = 0;

    axis_pkt_arbiter #(.NUM_IN(NI), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .resetn(resetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tid(m_axis_tid), .m_axis_tready(m_axis_tready),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void load(input int i, input int len, input int base, input bit rnd);
        logic [DW-1:0] b;
        for (int k = 0; k < len; k++) begin
            b = rnd ? DW'($urandom) : DW'(base + k);
            dq[i].push_back(b); mq[i].push_back(b);
            lq[i].push_back(k == len - 1); ml[i].push_back(k == len - 1);
        end
    endfunction

    // Round robin over whole packets: every input with a queued packet is requesting.
    function automatic void plan(input int msk, input int npk);
        int pick;
        int j;
        logic [DW-1:0] b;
        bit l;
        for (int p = 0; p < npk; p++) begin
            pick = -1;
            for (int k = 1; k <= NI; k++) begin
                j = (mlast + k) % NI;
                if (pick < 0 && msk[j] && mq[j].size() > 0) pick = j;
            end
            if (pick < 0) break;
            do begin
                b = mq[pick].pop_front();
                l = ml[pick].pop_front();
                eq.push_back({IW'(pick), l, b});
            end while (!l);
            mlast = pick;
            pkts++;
        end
    endfunction

    task automatic apb(input logic [11:0] a, input bit w, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1; rd = prdata; er = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (eq.size() != 0 && t < 3000) begin @(negedge clk); t++; end
        if (eq.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d beats outstanding, want 0", eq.size());
            eq.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    // Stream producers: hold a beat until accepted, bubbles only between beats of one packet.
    initial begin
        logic [NI-1:0] acc;
        bit first[NI];
        for (int i = 0; i < NI; i++) first[i] = 1'b1;
        s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tlast = '0;
        forever begin
            @(negedge clk);
            acc = s_axis_tvalid & s_axis_tready;
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                if (acc[i]) begin
                    first[i] = lq[i][0];
                    void'(dq[i].pop_front());
                    void'(lq[i].pop_front());
                end
                if (dq[i].size() == 0) s_axis_tvalid[i] = 1'b0;
                else if (!(s_axis_tvalid[i] && !acc[i])) begin
                    s_axis_tvalid[i] = !(bub && !first[i] && $urandom_range(3) == 0);
                    s_axis_tdata[i*DW +: DW] = dq[i][0];
                    s_axis_tlast[i] = lq[i][0];
                end
            end
        end
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_axis_tready = rmode == 0 ? 1'b1 : rmode == 1 ? ~m_axis_tready : 1'($urandom_range(1));
        end
    end

    // Monitor: pops the scoreboard on each output handshake and checks stability under stall.
    initial begin
        logic held = 1'b0;
        logic [PW-1:0] hv, got;
        bit plast = 1'b0;
        int pcyc = 0;
        forever begin
            @(negedge clk);
            got = {m_axis_tid, m_axis_tlast, m_axis_tdata};
            if (held) chk("stall_hold", 32'({m_axis_tvalid, got}), 32'({1'b1, hv}));
            if (m_axis_tvalid && m_axis_tready) begin
                if (eq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_beat: got 0x%0h, want no beat", got);
                end else chk("beat{tid,last,data}", 32'(got), 32'(eq.pop_front()));
                if (gap_chk && have && plast) chk("pkt_gap", 32'(cyc - pcyc), 32'd2);
                have = 1'b1; plast = m_axis_tlast; pcyc = cyc;
            end
            held = m_axis_tvalid && !m_axis_tready;
            hv = got;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic er;
        int t0, t1, t;
        resetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_m_out", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tid, m_axis_tdata}), 32'd0);
        chk("rst_apb", 32'({pready, pslverr, prdata}), {1'b1, 32'd0});
        @(posedge clk); #1; resetn = 1'b1;
        apb(12'h0, 1'b0, 32'd0, rd, er); chk("rst_ctrl", rd, 32'd1);
        apb(12'h4, 1'b0, 32'd0, rd, er); chk("rst_mask", rd, 32'd3);
        apb(12'h8, 1'b0, 32'd0, rd, er); chk("rst_status", rd, 32'd0);

        // Alternating 3-beat packets, full throughput, latency and inter-packet gap.
        gap_chk = 1'b1; have = 1'b0;
        for (int p = 0; p < 3; p++) begin load(0, 3, 'h10, 1'b0); load(1, 3, 'h20, 1'b0); end
        plan(3, 6);
        t = 0; while (s_axis_tvalid == '0 && t < 20) begin @(negedge clk); t++; end
        t0 = cyc;
        t = 0; while (!m_axis_tvalid && t < 20) begin @(negedge clk); t++; end
        t1 = cyc;
        chk("first_beat_latency", 32'(t1 - t0), 32'd2);
        drain();
        gap_chk = 1'b0;

        // Output stalled on alternate cycles.
        rmode = 1;
        load(0, 3, 'h10, 1'b0); load(1, 3, 'h20, 1'b0);
        plan(3, 2);
        drain();
        rmode = 0;

        // MASK change mid in1 packet; the packet finishes, then only in0 is served.
        load(0, 3, 'h30, 1'b0); load(0, 3, 'h38, 1'b0);
        load(1, 8, 'h40, 1'b0); load(1, 8, 'h50, 1'b0);
        plan(3, 2);
        t = 0;
        do begin @(negedge clk); t++; end while (!(s_axis_tvalid[1] && s_axis_tready[1]) && t < 200);
        chk("in1_granted", 32'(s_axis_tready), 32'd2);
        apb(12'h4, 1'b1, 32'h1, rd, er);
        apb(12'h8, 1'b0, 32'd0, rd, er); chk("status_busy", rd, 32'h101);
        plan(1, 1);
        drain();
        repeat (6) @(negedge clk);
        chk("masked_in1_idle", 32'(s_axis_tready), 32'd0);

        // ENABLE=0 blocks all grants; re-enable resumes after last_grant.
        apb(12'h0, 1'b1, 32'h0, rd, er);
        apb(12'h4, 1'b1, 32'h3, rd, er);
        load(0, 2, 'h60, 1'b0);
        repeat (2) @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("disabled_s_tready", 32'(s_axis_tready), 32'd0);
            chk("disabled_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        end
        apb(12'h0, 1'b1, 32'h1, rd, er);
        plan(3, 2);
        drain();

        // Address errors leave registers untouched.
        apb(12'h10, 1'b0, 32'd0, rd, er); chk("bad_addr_err", 32'(er), 32'd1); chk("bad_addr_data", rd, 32'd0);
        apb(12'h8, 1'b1, 32'hFF, rd, er); chk("status_wr_err", 32'(er), 32'd1);
        apb(12'h0, 1'b0, 32'd0, rd, er); chk("ctrl_kept", rd, 32'd1); chk("ctrl_rd_err", 32'(er), 32'd0);
        apb(12'h4, 1'b0, 32'd0, rd, er); chk("mask_kept", rd, 32'd3);
        apb(12'h8, 1'b0, 32'd0, rd, er); chk("status_idle", rd, 32'(mlast));
`ifdef AXIS_PKT_ARB_CNT_EN
        apb(12'hC, 1'b0, 32'd0, rd, er); chk("pkt_cnt", rd, 32'(pkts)); chk("pkt_cnt_err", 32'(er), 32'd0);
        apb(12'hC, 1'b1, 32'h5, rd, er); pkts = 0;
        apb(12'hC, 1'b0, 32'd0, rd, er); chk("pkt_cnt_cleared", rd, 32'd0);
`else
        apb(12'hC, 1'b0, 32'd0, rd, er); chk("cnt_off_err", 32'(er), 32'd1); chk("cnt_off_data", rd, 32'd0);
        apb(12'hC, 1'b1, 32'd1, rd, er); chk("cnt_off_wr_err", 32'(er), 32'd1);
`endif

        // Randomized packets, bubbles and backpressure.
        bub = 1'b1;
        for (int it = 0; it < 8; it++) begin
            rmode = (it % 2 == 0) ? 2 : 1;
            for (int i = 0; i < NI; i++)
                for (int p = $urandom_range(3); p > 0; p--) load(i, $urandom_range(1, 5), 0, 1'b1);
            plan(3, 100);
            drain();
        end
        rmode = 0; bub = 1'b0;
`ifdef AXIS_PKT_ARB_CNT_EN
        apb(12'hC, 1'b0, 32'd0, rd, er); chk("pkt_cnt_final", rd, 32'(pkts));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
